// File: rtl/ooo_reg_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// ooo_reg_scoreboard_pkg
//   Shared types and constants for the register busy scoreboard.
//   Contents:
//     REG_IDX_W    - architectural register index width
//     ROB_IDX_W    - ROB tag width
//     NUM_WB_PORTS - number of writeback ports
//     rob_tag_t    - ROB tag type
//     sb_entry_t   - per-register {busy, tag} cell contents
// ---------------------------------------------------------------------------
package ooo_reg_scoreboard_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int ROB_IDX_W    = 4;
  localparam int NUM_WB_PORTS = 2;

  typedef logic [ROB_IDX_W-1:0] rob_tag_t;

  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
  } sb_entry_t;

endpackage

// File: rtl/ooo_reg_scoreboard_entry.sv
// ---------------------------------------------------------------------------
// ooo_scoreboard_entry
//   One {busy, tag} cell of the busy table, for architectural register REG_IDX.
//   Next-state priority: flush > dispatch > matching writeback > hold.
//   Ports:
//     CLK, nRST        clock / async active-low reset
//     i_flush          clear busy
//     i_dispatch_en    a writer leaves decode this cycle
//     i_dispatch_rd    its destination register
//     i_dispatch_tag   its ROB tag
//     i_wb_en/rd/tag   per-port writeback
//     o_busy           registered busy bit
//     o_wb_match       busy and some writeback port carries this register and tag
//     o_dispatch_hit   the dispatch this cycle targets this register
// ---------------------------------------------------------------------------
module ooo_scoreboard_entry
  import ooo_reg_scoreboard_pkg::*;
#(
  parameter int REG_IDX = 1,
  parameter int NUM_WB  = NUM_WB_PORTS
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             i_flush,
  input  logic                             i_dispatch_en,
  input  logic [REG_IDX_W-1:0]             i_dispatch_rd,
  input  rob_tag_t                         i_dispatch_tag,
  input  logic [NUM_WB-1:0]                i_wb_en,
  input  logic [NUM_WB-1:0][REG_IDX_W-1:0] i_wb_rd,
  input  rob_tag_t [NUM_WB-1:0]            i_wb_tag,
  output logic                             o_busy,
  output logic                             o_wb_match,
  output logic                             o_dispatch_hit
);

  localparam logic [REG_IDX_W-1:0] IDX = REG_IDX_W'(REG_IDX);

  sb_entry_t r_entry;
  sb_entry_t w_entry_next;
  logic      w_wb_match;
  logic      w_dispatch_hit;

  assign w_dispatch_hit = i_dispatch_en && (i_dispatch_rd == IDX);

  // Several ports hitting the same entry collapse into one clear. A tag
  // mismatch is a stale writer whose register was re-dispatched; ignore it.
  always_comb begin
    w_wb_match = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (i_wb_en[p] && (i_wb_rd[p] == IDX) && (i_wb_tag[p] == r_entry.tag)) begin
        w_wb_match = 1'b1;
      end
    end
    w_wb_match = w_wb_match & r_entry.busy;
  end

  // NOTE: the next state starts as "hold" before the priority chain, so every
  // path assigns it and no latch is inferred.
  always_comb begin
    w_entry_next = r_entry;
    if (i_flush) begin
      w_entry_next.busy = 1'b0;
    end else if (w_dispatch_hit) begin
      w_entry_next.busy = 1'b1;
      w_entry_next.tag  = i_dispatch_tag;
    end else if (w_wb_match) begin
      w_entry_next.busy = 1'b0;
    end
  end

  // NOTE: non-blocking assignment so every entry and the counter sample the
  // same pre-edge state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_entry <= '0;
    end else begin
      r_entry <= w_entry_next;
    end
  end

  assign o_busy         = r_entry.busy;
  assign o_wb_match     = w_wb_match;
  assign o_dispatch_hit = w_dispatch_hit;

endmodule

// File: rtl/ooo_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// ooo_reg_scoreboard
//   Per-architectural-register busy table. Dispatch sets a register busy with
//   its ROB tag, the matching writeback clears it, flush clears everything.
//   Ports:
//     CLK, nRST                  clock / async active-low reset
//     dispatch_en/rd/tag         writer leaving decode
//     wb_en/rd/tag [NUM_WB]      writeback ports
//     flush                      clear all entries
//     rs1_sel/rs2_sel/rd_sel     lookup selects from decode
//     rs1_busy/rs2_busy/rd_busy  lookup results (with optional writeback bypass)
//     busy_vec                   registered busy bits, bit 0 always 0
//     inflight_cnt               registered count of busy registers
//     sb_empty                   inflight_cnt == 0
// ---------------------------------------------------------------------------
module ooo_reg_scoreboard
  import ooo_reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int ROB_IDX_W = ooo_reg_scoreboard_pkg::ROB_IDX_W,
  parameter int NUM_WB    = NUM_WB_PORTS,
  parameter int WB_BYPASS = 1,
  localparam int CNT_W    = $clog2(NUM_REGS) + 1
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             dispatch_en,
  input  logic [REG_IDX_W-1:0]             dispatch_rd,
  input  logic [ROB_IDX_W-1:0]             dispatch_tag,
  input  logic [NUM_WB-1:0]                wb_en,
  input  logic [NUM_WB-1:0][REG_IDX_W-1:0] wb_rd,
  input  logic [NUM_WB-1:0][ROB_IDX_W-1:0] wb_tag,
  input  logic                             flush,
  input  logic [REG_IDX_W-1:0]             rs1_sel,
  input  logic [REG_IDX_W-1:0]             rs2_sel,
  input  logic [REG_IDX_W-1:0]             rd_sel,
  output logic                             rs1_busy,
  output logic                             rs2_busy,
  output logic                             rd_busy,
  output logic [NUM_REGS-1:0]              busy_vec,
  output logic [CNT_W-1:0]                 inflight_cnt,
  output logic                             sb_empty
);

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_wb_match;
  logic [NUM_REGS-1:0] w_dispatch_hit;
  logic [NUM_REGS-1:0] w_lookup;
  logic [CNT_W-1:0]    w_clears;
  logic                w_set;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    r_cnt;

  // x0 is hardwired not-busy and never matches anything.
  assign w_busy[0]         = 1'b0;
  assign w_wb_match[0]     = 1'b0;
  assign w_dispatch_hit[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    ooo_scoreboard_entry #(
      .REG_IDX (r),
      .NUM_WB  (NUM_WB)
    ) u_entry (
      .CLK            (CLK),
      .nRST           (nRST),
      .i_flush        (flush),
      .i_dispatch_en  (dispatch_en),
      .i_dispatch_rd  (dispatch_rd),
      .i_dispatch_tag (dispatch_tag),
      .i_wb_en        (wb_en),
      .i_wb_rd        (wb_rd),
      .i_wb_tag       (wb_tag),
      .o_busy         (w_busy[r]),
      .o_wb_match     (w_wb_match[r]),
      .o_dispatch_hit (w_dispatch_hit[r])
    );
  end

  // Writeback bypass hides an entry being cleared this cycle. Dispatch and
  // flush are deliberately not bypassed.
  assign w_lookup = (WB_BYPASS != 0) ? (w_busy & ~w_wb_match) : w_busy;

  assign rs1_busy = w_lookup[rs1_sel];
  assign rs2_busy = w_lookup[rs2_sel];
  assign rd_busy  = w_lookup[rd_sel];
  assign busy_vec = w_busy;

  // A re-dispatch to a busy entry adds nothing, and a writeback to the entry
  // being dispatched this cycle is overridden, so it does not count as a clear.
  assign w_set = |(w_dispatch_hit & ~w_busy);

  always_comb begin
    w_clears = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_clears = w_clears + CNT_W'(w_wb_match[r] & ~w_dispatch_hit[r]);
    end
  end

  assign w_cnt_next = r_cnt + CNT_W'(w_set) - w_clears;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign inflight_cnt = r_cnt;
  assign sb_empty     = (r_cnt == '0);

  a_cnt_matches_busy : assert property (@(posedge CLK) disable iff (!nRST)
    inflight_cnt == CNT_W'($countones(busy_vec)));

  // The hazard unit should have stalled on rd_busy; the tag is overwritten anyway.
  a_no_busy_redispatch : assert property (@(posedge CLK) disable iff (!nRST)
    !(dispatch_en && !flush && w_lookup[dispatch_rd]))
    else $warning("dispatch to busy register x%0d", dispatch_rd);

endmodule

// File: tb/tb_ooo_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_ooo_reg_scoreboard
//   Directed scenarios plus randomized traffic against a reference model of
//   the busy table kept as plain arrays of {busy, tag}.
// ---------------------------------------------------------------------------
module tb_ooo_reg_scoreboard;

  localparam int NR = 32;
  localparam int TW = 4;
  localparam int NW = 2;
  localparam int CW = 6;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic                 dispatch_en;
  logic [4:0]           dispatch_rd;
  logic [TW-1:0]        dispatch_tag;
  logic [NW-1:0]        wb_en;
  logic [NW-1:0][4:0]   wb_rd;
  logic [NW-1:0][TW-1:0] wb_tag;
  logic                 flush;
  logic [4:0]           rs1_sel, rs2_sel, rd_sel;
  logic                 rs1_busy, rs2_busy, rd_busy;
  logic [NR-1:0]        busy_vec;
  logic [CW-1:0]        inflight_cnt;
  logic                 sb_empty;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_busy[NR];
  int m_tag[NR];

  ooo_reg_scoreboard #(
    .NUM_REGS (NR), .ROB_IDX_W (TW), .NUM_WB (NW), .WB_BYPASS (1)
  ) dut (
    .CLK (CLK), .nRST (nRST),
    .dispatch_en (dispatch_en), .dispatch_rd (dispatch_rd), .dispatch_tag (dispatch_tag),
    .wb_en (wb_en), .wb_rd (wb_rd), .wb_tag (wb_tag), .flush (flush),
    .rs1_sel (rs1_sel), .rs2_sel (rs2_sel), .rd_sel (rd_sel),
    .rs1_busy (rs1_busy), .rs2_busy (rs2_busy), .rd_busy (rd_busy),
    .busy_vec (busy_vec), .inflight_cnt (inflight_cnt), .sb_empty (sb_empty)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic bit m_wb_hits(int r);
    if (r == 0 || !m_busy[r]) return 1'b0;
    for (int p = 0; p < NW; p++)
      if (wb_en[p] && int'(wb_rd[p]) == r && int'(wb_tag[p]) == m_tag[r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_lookup(int r);
    return (r != 0) && m_busy[r] && !m_wb_hits(r);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NR; r++) begin
      m_busy[r] = 1'b0;
      m_tag[r]  = 0;
    end
  endtask

  task automatic m_update();
    bit hit[NR];
    for (int r = 0; r < NR; r++) hit[r] = m_wb_hits(r);
    if (!nRST || flush) begin
      for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        if (dispatch_en && int'(dispatch_rd) == r) begin
          m_busy[r] = 1'b1;
          m_tag[r]  = int'(dispatch_tag);
        end else if (hit[r]) begin
          m_busy[r] = 1'b0;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    dispatch_en = 1'b0; dispatch_rd = '0; dispatch_tag = '0;
    wb_en = '0; wb_rd = '0; wb_tag = '0; flush = 1'b0;
    rs1_sel = '0; rs2_sel = '0; rd_sel = '0;
  endtask

  // Clock edge with model update; returns 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    m_update();
    #1;
  endtask

  task automatic dispatch_one(int rd, int tag);
    dispatch_en = 1'b1; dispatch_rd = 5'(rd); dispatch_tag = TW'(tag);
    tick();
    dispatch_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b0;
    drive_idle();
    m_clear();
    #12;
    n_tests++; if (busy_vec !== '0)         begin n_fail++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec); end
    n_tests++; if (inflight_cnt !== '0)     begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", inflight_cnt); end
    n_tests++; if (sb_empty !== 1'b1)       begin n_fail++; $display("FAIL reset_empty: got %b want 1", sb_empty); end
    n_tests++; if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_lookup: got %b want 000", {rs1_busy, rs2_busy, rd_busy}); end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    tick();
    dispatch_one(3, 1);
    dispatch_one(4, 2);
    n_tests++; if (inflight_cnt !== CW'(2)) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d want 2", inflight_cnt); end
    // Assert reset between edges: outputs must clear without a clock.
    #2;
    nRST = 1'b0;
    #1;
    m_clear();
    n_tests++; if (busy_vec !== '0)         begin n_fail++; $display("FAIL async_reset_busy_vec: got %h want 0", busy_vec); end
    n_tests++; if (inflight_cnt !== '0)     begin n_fail++; $display("FAIL async_reset_cnt: got %0d want 0", inflight_cnt); end
    n_tests++; if (sb_empty !== 1'b1)       begin n_fail++; $display("FAIL async_reset_empty: got %b want 1", sb_empty); end
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_dispatch_wb();
    dispatch_one(5, 3);
    rs1_sel = 5'd5;
    #1;
    n_tests++; if (rs1_busy !== 1'b1)       begin n_fail++; $display("FAIL disp_rs1_busy: got %b want 1", rs1_busy); end
    n_tests++; if (inflight_cnt !== CW'(1)) begin n_fail++; $display("FAIL disp_cnt: got %0d want 1", inflight_cnt); end
    wb_en = 2'b01; wb_rd[0] = 5'd5; wb_tag[0] = 4'd3;
    #1;
    n_tests++; if (rs1_busy !== 1'b0)       begin n_fail++; $display("FAIL wb_bypass: got %b want 0", rs1_busy); end
    n_tests++; if (busy_vec[5] !== 1'b1)    begin n_fail++; $display("FAIL wb_registered: got %b want 1", busy_vec[5]); end
    tick();
    wb_en = '0;
    n_tests++; if (inflight_cnt !== CW'(0)) begin n_fail++; $display("FAIL wb_cnt: got %0d want 0", inflight_cnt); end
    n_tests++; if (sb_empty !== 1'b1)       begin n_fail++; $display("FAIL wb_empty: got %b want 1", sb_empty); end
  endtask

  task automatic test_stale_wb();
    dispatch_one(7, 2);
    dispatch_one(7, 9);
    rs2_sel = 5'd7;
    wb_en = 2'b01; wb_rd[0] = 5'd7; wb_tag[0] = 4'd2;
    #1;
    n_tests++; if (rs2_busy !== 1'b1)       begin n_fail++; $display("FAIL stale_lookup: got %b want 1", rs2_busy); end
    tick();
    n_tests++; if (busy_vec[7] !== 1'b1)    begin n_fail++; $display("FAIL stale_busy: got %b want 1", busy_vec[7]); end
    n_tests++; if (inflight_cnt !== CW'(1)) begin n_fail++; $display("FAIL stale_cnt: got %0d want 1", inflight_cnt); end
    wb_tag[0] = 4'd9;
    #1;
    n_tests++; if (rs2_busy !== 1'b0)       begin n_fail++; $display("FAIL new_tag_bypass: got %b want 0", rs2_busy); end
    tick();
    wb_en = '0;
    n_tests++; if (busy_vec[7] !== 1'b0)    begin n_fail++; $display("FAIL new_tag_clear: got %b want 0", busy_vec[7]); end
    n_tests++; if (inflight_cnt !== CW'(0)) begin n_fail++; $display("FAIL new_tag_cnt: got %0d want 0", inflight_cnt); end
  endtask

  task automatic test_same_cycle();
    dispatch_one(9, 1);
    dispatch_en = 1'b1; dispatch_rd = 5'd9; dispatch_tag = 4'd4;
    wb_en = 2'b10; wb_rd[1] = 5'd9; wb_tag[1] = 4'd1;
    rd_sel = 5'd9;
    #1;
    n_tests++; if (rd_busy !== 1'b0)        begin n_fail++; $display("FAIL same_cycle_bypass: got %b want 0", rd_busy); end
    tick();
    dispatch_en = 1'b0; wb_en = '0;
    n_tests++; if (busy_vec[9] !== 1'b1)    begin n_fail++; $display("FAIL same_cycle_busy: got %b want 1", busy_vec[9]); end
    n_tests++; if (inflight_cnt !== CW'(1)) begin n_fail++; $display("FAIL same_cycle_cnt: got %0d want 1", inflight_cnt); end
    // The stored tag must be the new one: old tag no longer clears it.
    wb_en = 2'b01; wb_rd[0] = 5'd9; wb_tag[0] = 4'd1;
    tick();
    n_tests++; if (busy_vec[9] !== 1'b1)    begin n_fail++; $display("FAIL same_cycle_old_tag: got %b want 1", busy_vec[9]); end
    wb_tag[0] = 4'd4;
    tick();
    wb_en = '0;
    n_tests++; if (busy_vec[9] !== 1'b0)    begin n_fail++; $display("FAIL same_cycle_new_tag: got %b want 0", busy_vec[9]); end
  endtask

  task automatic test_flush();
    dispatch_one(1, 10);
    dispatch_one(2, 11);
    dispatch_one(3, 12);
    n_tests++; if (inflight_cnt !== CW'(3)) begin n_fail++; $display("FAIL pre_flush_cnt: got %0d want 3", inflight_cnt); end
    flush = 1'b1;
    dispatch_en = 1'b1; dispatch_rd = 5'd4; dispatch_tag = 4'd5;
    wb_en = 2'b01; wb_rd[0] = 5'd2; wb_tag[0] = 4'd11;
    rs1_sel = 5'd2; rs2_sel = 5'd1;
    #1;
    n_tests++; if (rs1_busy !== 1'b0)       begin n_fail++; $display("FAIL flush_wb_bypass: got %b want 0", rs1_busy); end
    n_tests++; if (rs2_busy !== 1'b1)       begin n_fail++; $display("FAIL flush_no_bypass: got %b want 1", rs2_busy); end
    tick();
    drive_idle();
    n_tests++; if (busy_vec !== '0)         begin n_fail++; $display("FAIL flush_busy_vec: got %h want 0", busy_vec); end
    n_tests++; if (inflight_cnt !== CW'(0)) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", inflight_cnt); end
  endtask

  task automatic test_x0_dual_wb();
    dispatch_one(6, 7);
    dispatch_en = 1'b1; dispatch_rd = 5'd0; dispatch_tag = 4'd3;
    wb_en = 2'b01; wb_rd[0] = 5'd0; wb_tag[0] = 4'd0;
    rs1_sel = 5'd0;
    #1;
    n_tests++; if (rs1_busy !== 1'b0)       begin n_fail++; $display("FAIL x0_lookup: got %b want 0", rs1_busy); end
    tick();
    drive_idle();
    n_tests++; if (inflight_cnt !== CW'(1)) begin n_fail++; $display("FAIL x0_cnt: got %0d want 1", inflight_cnt); end
    n_tests++; if (busy_vec[0] !== 1'b0)    begin n_fail++; $display("FAIL x0_busy: got %b want 0", busy_vec[0]); end
    wb_en = 2'b11; wb_rd[0] = 5'd6; wb_rd[1] = 5'd6; wb_tag[0] = 4'd7; wb_tag[1] = 4'd7;
    tick();
    drive_idle();
    n_tests++; if (inflight_cnt !== CW'(0)) begin n_fail++; $display("FAIL dual_wb_cnt: got %0d want 0", inflight_cnt); end
    n_tests++; if (busy_vec[6] !== 1'b0)    begin n_fail++; $display("FAIL dual_wb_busy: got %b want 0", busy_vec[6]); end
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR-1)) : int'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_idle();
      for (int p = 0; p < NW; p++) begin
        int r;
        wb_en[p] = ($urandom_range(0, 9) < 6);
        r = pick_reg();
        wb_rd[p] = 5'(r);
        wb_tag[p] = ($urandom_range(0, 9) < 7) ? TW'(m_tag[r]) : TW'($urandom);
      end
      begin
        int r = pick_reg();
        dispatch_rd  = 5'(r);
        dispatch_tag = TW'($urandom);
        dispatch_en  = ($urandom_range(0, 1) == 1) && !m_lookup(r);
      end
      flush   = ($urandom_range(0, 49) == 0);
      rs1_sel = 5'(pick_reg());
      rs2_sel = 5'(pick_reg());
      rd_sel  = 5'(pick_reg());
      #1;
      n_tests++; if (rs1_busy !== m_lookup(int'(rs1_sel))) begin n_fail++; $display("FAIL rnd_rs1 cyc %0d x%0d: got %b want %b", cyc, rs1_sel, rs1_busy, m_lookup(int'(rs1_sel))); end
      n_tests++; if (rs2_busy !== m_lookup(int'(rs2_sel))) begin n_fail++; $display("FAIL rnd_rs2 cyc %0d x%0d: got %b want %b", cyc, rs2_sel, rs2_busy, m_lookup(int'(rs2_sel))); end
      n_tests++; if (rd_busy  !== m_lookup(int'(rd_sel)))  begin n_fail++; $display("FAIL rnd_rd cyc %0d x%0d: got %b want %b", cyc, rd_sel, rd_busy, m_lookup(int'(rd_sel))); end
      tick();
      n_tests++; if (busy_vec !== m_vec()) begin n_fail++; $display("FAIL rnd_busy_vec cyc %0d: got %h want %h", cyc, busy_vec, m_vec()); end
      n_tests++; if (inflight_cnt !== CW'(m_count())) begin n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", cyc, inflight_cnt, m_count()); end
      n_tests++; if (sb_empty !== (m_count() == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d: got %b want %b", cyc, sb_empty, m_count() == 0); end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_dispatch_wb();
    test_stale_wb();
    test_same_cycle();
    test_flush();
    test_x0_dual_wb();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
